// File: rtl/lcrc_sched.sv
// lcrc_sched: shares one byte-serial LCRC-32 engine between the new-TLP
// requester and the replay requester. One requester is granted per packet.
// Its bytes stream through a single output register while the reflected
// CRC-32 accumulates. The inverted CRC is then appended, low byte first.
// Optional feature: define LCRC_SCHED_RR_EN for round-robin arbitration.
// Without it, replay has fixed priority over new.
module lcrc_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_valid,
    input  logic [7:0] new_data,
    input  logic       new_last,
    output logic       new_ready,
    input  logic       rpl_valid,
    input  logic [7:0] rpl_data,
    input  logic       rpl_last,
    output logic       rpl_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_src,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [31:0] POLY_REFL = 32'hEDB88320;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    state_t      state_reg;
    logic        grant_reg;
    logic [31:0] crc_reg;
    logic [1:0]  idx_reg;

    logic        out_free;
    logic        sel_valid;
    logic [7:0]  sel_data;
    logic        sel_last;
    logic        take;
    logic        next_grant;
    logic [31:0] crc_inv;
    logic [7:0]  crc_byte;
    logic [31:0] crc_chain [0:8];

    // The output register can take a new byte when empty or being drained.
    assign out_free  = !out_valid || out_ready;

    // Only the granted requester's signals ever reach the data path.
    assign sel_valid = grant_reg ? rpl_valid : new_valid;
    assign sel_data  = grant_reg ? rpl_data  : new_data;
    assign sel_last  = grant_reg ? rpl_last  : new_last;

    assign new_ready = (state_reg == DATA) && !grant_reg && out_free;
    assign rpl_ready = (state_reg == DATA) &&  grant_reg && out_free;
    assign take      = (state_reg == DATA) && sel_valid && out_free;
    assign busy      = (state_reg != IDLE);

    // Byte-wide reflected CRC update, unrolled as eight one-bit shifts.
    // The byte's LSB is processed first.
    assign crc_chain[0] = crc_reg ^ {24'h0, sel_data};
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
            assign crc_chain[gi+1] = crc_chain[gi][0]
                                   ? ((crc_chain[gi] >> 1) ^ POLY_REFL)
                                   :  (crc_chain[gi] >> 1);
        end
    endgenerate

    // Transmitted LCRC is the complement, sent low byte first.
    assign crc_inv = ~crc_reg;
    always_comb begin
        crc_byte = crc_inv[7:0];
        case (idx_reg)
            2'd0: crc_byte = crc_inv[7:0];
            2'd1: crc_byte = crc_inv[15:8];
            2'd2: crc_byte = crc_inv[23:16];
            2'd3: crc_byte = crc_inv[31:24];
            default: crc_byte = crc_inv[7:0];
        endcase
    end

`ifdef LCRC_SCHED_RR_EN
    // Round-robin pointer: 0 means the new-TLP side wins the next tie.
    logic rr_reg;

    // On a tie the side named by the pointer wins; a lone requester always wins.
    always_comb begin
        next_grant = rpl_valid;
        if (new_valid && rpl_valid) begin
            next_grant = rr_reg;
        end
    end

    // Point at the side that was not granted at each grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_reg <= 1'b0;
        end else if (state_reg == IDLE && (new_valid || rpl_valid)) begin
            rr_reg <= !next_grant;
        end
    end
`else
    // Fixed priority: replay beats new whenever it is requesting.
    always_comb begin
        next_grant = rpl_valid;
    end
`endif

    // Packet FSM, output register and CRC accumulator.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            crc_reg   <= 32'hFFFFFFFF;
            idx_reg   <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else begin
            // A consumed byte empties the register unless refilled below.
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (new_valid || rpl_valid) begin
                        grant_reg <= next_grant;
                        crc_reg   <= 32'hFFFFFFFF;
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (take) begin
                        out_valid <= 1'b1;
                        out_data  <= sel_data;
                        out_last  <= 1'b0;
                        out_src   <= grant_reg;
                        crc_reg   <= crc_chain[8];
                        if (sel_last) begin
                            idx_reg   <= 2'd0;
                            state_reg <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= crc_byte;
                        out_last  <= (idx_reg == 2'd3);
                        out_src   <= grant_reg;
                        idx_reg   <= idx_reg + 2'd1;
                        if (idx_reg == 2'd3) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcrc_sched.sv
// tb_lcrc_sched: directed bench for lcrc_sched. A packet-level model computes
// the expected output stream (payload, then the software CRC-32 low byte first)
// in grant order. One compare process checks every consumed output byte
// and the hold behaviour under backpressure. Literal checks pin the model.
module tb_lcrc_sched;

    logic       clk;
    logic       reset;
    logic       new_valid;
    logic [7:0] new_data;
    logic       new_last;
    logic       new_ready;
    logic       rpl_valid;
    logic [7:0] rpl_data;
    logic       rpl_last;
    logic       rpl_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_src;
    logic       out_ready;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       src;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cap_data[$];
    logic       cap_last[$];
    logic       cap_src[$];
    bit         chk_en = 1'b1;
    bit         rnd_ready = 1'b0;

    lcrc_sched dut (
        .clk       (clk),
        .reset     (reset),
        .new_valid (new_valid),
        .new_data  (new_data),
        .new_last  (new_last),
        .new_ready (new_ready),
        .rpl_valid (rpl_valid),
        .rpl_data  (rpl_data),
        .rpl_last  (rpl_last),
        .rpl_ready (rpl_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream: always ready, or coin-flip backpressure when enabled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Software reflected CRC-32 (init all ones, final complement).
    function automatic logic [31:0] crc32(input logic [7:0] d[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
                else      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Expected stream of one packet: its bytes, then four LCRC bytes.
    task automatic push_exp(input bit src, input logic [7:0] d[$]);
        logic [31:0] c;
        c = crc32(d);
        foreach (d[i]) exp_q.push_back('{data: d[i], last: 1'b0, src: src});
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{data: c[8*k +: 8], last: (k == 3), src: src});
    endtask

    // Drive one packet. Optional gap (valid low) before byte gap_at.
    // Returns early, valid still high, when stop_after bytes are accepted.
    task automatic send_pkt(input bit src, input logic [7:0] d[$], input int gap_at,
                            input int gap_len, input int stop_after);
        bit hs;
        int t;
        for (int i = 0; i < d.size(); i++) begin
            if (i == stop_after) return;
            if (i == gap_at) begin
                if (src) rpl_valid = 1'b0; else new_valid = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            if (src) begin
                rpl_valid = 1'b1; rpl_data = d[i]; rpl_last = (i == d.size() - 1);
            end else begin
                new_valid = 1'b1; new_data = d[i]; new_last = (i == d.size() - 1);
            end
            t = 0;
            do begin
                @(negedge clk);
                hs = src ? rpl_ready : new_ready;
                @(posedge clk);
                #1;
                t++;
            end while (!hs && t < 2000);
            if (!hs) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout: src=%0d byte=%0d got no ready required ready", src, i);
                return;
            end
        end
        if (src) begin rpl_valid = 1'b0; rpl_last = 1'b0; end
        else     begin new_valid = 1'b0; new_last = 1'b0; end
    endtask

    task automatic wait_idle(input string name);
        int t;
        bit ok;
        ok = 1'b0;
        for (t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_drain: got %0d bytes outstanding expected 0", name, exp_q.size());
        end
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_last.delete();
        cap_src.delete();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_out_data"},  32'(out_data),  32'd0);
        chk({name, "_out_last"},  32'(out_last),  32'd0);
        chk({name, "_out_src"},   32'(out_src),   32'd0);
        chk({name, "_readies"},   32'({new_ready, rpl_ready}), 32'd0);
        chk({name, "_busy"},      32'(busy),      32'd0);
    endtask

    // Compare process: every consumed byte against the model, and hold
    // stability whenever the previous cycle was stalled.
    initial begin
        exp_t       e;
        bit         prev_hold;
        logic [7:0] prev_data;
        logic       prev_last;
        logic       prev_src;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        prev_src  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && chk_en) begin
                if (new_ready && rpl_ready) begin
                    checks++;
                    failures++;
                    $display("FAIL both_ready: got new_ready=1 rpl_ready=1 expected at most one");
                end
                if (prev_hold) begin
                    checks++;
                    if (!out_valid || out_data !== prev_data || out_last !== prev_last
                        || out_src !== prev_src) begin
                        failures++;
                        $display("FAIL hold: got v=%0d d=%h l=%0d s=%0d expected v=1 d=%h l=%0d s=%0d",
                                 out_valid, out_data, out_last, out_src, prev_data, prev_last, prev_src);
                    end
                end
                if (out_valid && out_ready) begin
                    cap_data.push_back(out_data);
                    cap_last.push_back(out_last);
                    cap_src.push_back(out_src);
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL stream_extra: got d=%h l=%0d s=%0d expected no byte",
                                 out_data, out_last, out_src);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e.data || out_last !== e.last || out_src !== e.src) begin
                            failures++;
                            $display("FAIL stream: got d=%h l=%0d s=%0d expected d=%h l=%0d s=%0d",
                                     out_data, out_last, out_src, e.data, e.last, e.src);
                        end
                    end
                end
            end
            prev_hold = reset && out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            prev_src  = out_src;
        end
    end

    initial begin
        logic [7:0] pkt9[$];
        logic [7:0] zero1[$];
        logic [7:0] big[$];
        logic [7:0] d6[$];
        logic [7:0] r2[$];
        logic [7:0] one[$];
        bit         any_src;

        reset = 1'b0;
        new_valid = 1'b0; new_data = '0; new_last = 1'b0;
        rpl_valid = 1'b0; rpl_data = '0; rpl_last = 1'b0;
        pkt9  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        zero1 = '{8'h00};

        // Model pins: standard CRC-32 check values.
        chk("model_crc_123456789", crc32(pkt9), 32'hCBF43926);
        chk("model_crc_zero",      crc32(zero1), 32'hD202EF8D);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // New-TLP "123456789".
        clear_cap();
        push_exp(1'b0, pkt9);
        send_pkt(1'b0, pkt9, -1, 0, -1);
        wait_idle("t1");
        chk("t1_count", cap_data.size(), 32'd13);
        chk("t1_crc0", 32'(cap_data[9]),  32'h26);
        chk("t1_crc1", 32'(cap_data[10]), 32'h39);
        chk("t1_crc2", 32'(cap_data[11]), 32'hF4);
        chk("t1_crc3", 32'(cap_data[12]), 32'hCB);
        chk("t1_last", 32'({cap_last[11], cap_last[12]}), 32'b01);
        any_src = 1'b0;
        foreach (cap_src[i]) any_src |= cap_src[i];
        chk("t1_src", 32'(any_src), 32'd0);

        // Single replay byte 0x00.
        clear_cap();
        push_exp(1'b1, zero1);
        send_pkt(1'b1, zero1, -1, 0, -1);
        wait_idle("t2");
        chk("t2_count", cap_data.size(), 32'd5);
        chk("t2_lcrc", {cap_data[4], cap_data[3], cap_data[2], cap_data[1]}, 32'hD202EF8D);
        chk("t2_src_last", 32'({cap_src[0], cap_last[4]}), 32'b11);

        // Both requesting: three 1-byte packets each, back to back.
        clear_cap();
`ifdef LCRC_SCHED_RR_EN
        for (int p = 0; p < 3; p++) begin
            one = '{8'hA0 + 8'(p)}; push_exp(1'b0, one);
            one = '{8'hB0 + 8'(p)}; push_exp(1'b1, one);
        end
`else
        for (int p = 0; p < 3; p++) begin one = '{8'hB0 + 8'(p)}; push_exp(1'b1, one); end
        for (int p = 0; p < 3; p++) begin one = '{8'hA0 + 8'(p)}; push_exp(1'b0, one); end
`endif
        fork
            begin
                logic [7:0] q[$];
                for (int p = 0; p < 3; p++) begin q = '{8'hA0 + 8'(p)}; send_pkt(1'b0, q, -1, 0, -1); end
            end
            begin
                logic [7:0] q[$];
                for (int p = 0; p < 3; p++) begin q = '{8'hB0 + 8'(p)}; send_pkt(1'b1, q, -1, 0, -1); end
            end
        join
        wait_idle("t3");
        chk("t3_count", cap_data.size(), 32'd30);
`ifdef LCRC_SCHED_RR_EN
        chk("t3_first", 32'({cap_src[0], cap_src[5], cap_src[10]}), 32'b010);
`else
        chk("t3_first", 32'({cap_src[0], cap_src[10], cap_src[15]}), 32'b110);
`endif

        // 64-byte packet under random backpressure.
        clear_cap();
        big.delete();
        for (int i = 0; i < 64; i++) big.push_back(8'(i * 37 + 5));
        push_exp(1'b0, big);
        rnd_ready = 1'b1;
        send_pkt(1'b0, big, -1, 0, -1);
        wait_idle("t4");
        rnd_ready = 1'b0;
        chk("t4_count", cap_data.size(), 32'd68);

        // New drops valid for 5 cycles mid-packet while replay waits.
        clear_cap();
        d6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        r2 = '{8'h77, 8'h88};
        push_exp(1'b0, d6);
        push_exp(1'b1, r2);
        fork
            send_pkt(1'b0, d6, 2, 5, -1);
            begin
                repeat (3) @(posedge clk);
                #1;
                send_pkt(1'b1, r2, -1, 0, -1);
            end
        join
        wait_idle("t5");
        chk("t5_switch", 32'({cap_src[9], cap_src[10]}), 32'b01);

        // Reset after 3 accepted bytes, then a clean "123456789".
        chk_en = 1'b0;
        send_pkt(1'b0, pkt9, -1, 0, 3);
        reset = 1'b0;
        new_valid = 1'b0;
        new_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("t6_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        clear_cap();
        chk_en = 1'b1;
        push_exp(1'b0, pkt9);
        send_pkt(1'b0, pkt9, -1, 0, -1);
        wait_idle("t6");
        chk("t6_count", cap_data.size(), 32'd13);
        chk("t6_lcrc", {cap_data[12], cap_data[11], cap_data[10], cap_data[9]}, 32'hCBF43926);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
